skinny_sbox_layer_ctrl: RTL and testbench

Serialising controller that applies the 4-bit Skinny-64 S-box to all nibbles of a 64-bit cipher state using a single shared S-box instance. It sits between the round-state register and the one S-box netlist. The S-box has a one-cycle registered output. The controller feeds one nibble per cycle, realigns the delayed outputs, and returns the substituted state with a start/busy/done handshake.

---
 rtl/skinny_sbox_layer_ctrl.sv | 95 +++++++++
 tb/tb_skinny_sbox_layer_ctrl.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/skinny_sbox_layer_ctrl.sv
// Serialises the Skinny-64 4-bit S-box over all nibbles of the cipher state
// through one shared registered S-box, realigning its delayed output into dout.
`timescale 1ns/1ps
module skinny_sbox_layer_ctrl #(
    parameter int NIBBLES = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [4*NIBBLES-1:0]   din,
    output logic [4*NIBBLES-1:0]   dout,
    output logic                   busy,
    output logic                   done
);
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]           state;
    logic [4*NIBBLES-1:0] src_q;
    logic [IW-1:0]        idx;
    logic [IW-1:0]        widx_q;
    logic                 v_q;
    logic [3:0]           sb_x;
    logic [3:0]           sb_y;

    function automatic logic [3:0] sbox4(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'hC;  4'h1: y = 4'h6;  4'h2: y = 4'h9;  4'h3: y = 4'h0;
            4'h4: y = 4'h1;  4'h5: y = 4'hA;  4'h6: y = 4'h2;  4'h7: y = 4'hB;
            4'h8: y = 4'h3;  4'h9: y = 4'h8;  4'hA: y = 4'h5;  4'hB: y = 4'hD;
            4'hC: y = 4'h4;  4'hD: y = 4'hE;  4'hE: y = 4'h7;  default: y = 4'hF;
        endcase
        return y;
    endfunction

    // Feed stage: one lane per RUN cycle, driven only from registers
    always_comb begin
        sb_x = 4'h0;
        if (state == S_RUN)
            sb_x = src_q[4*idx +: 4];
    end

    // Shared S-box output register; deliberately unreset, guarded by v_q
    always_ff @(posedge clk)
        sb_y <= sbox4(sb_x);

    assign busy = (state == S_RUN) || (state == S_DRAIN);
    assign done = (state == S_DONE);

    // Control and align stage: sb_y lags sb_x by one edge, widx_q tracks it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            src_q  <= '0;
            idx    <= '0;
            widx_q <= '0;
            v_q    <= 1'b0;
            dout   <= '0;
        end else begin
            if (v_q)
                dout[4*widx_q +: 4] <= sb_y;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_RUN;
                        src_q <= din;
                        idx   <= '0;
                        v_q   <= 1'b0;
                    end
                end
                S_RUN: begin
                    v_q    <= 1'b1;
                    widx_q <= idx;
                    if (idx == LAST) begin
                        state <= S_DRAIN;
                        idx   <= '0;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                S_DRAIN: begin
                    v_q   <= 1'b0;
                    state <= S_DONE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_skinny_sbox_layer_ctrl.sv
// Bench for skinny_sbox_layer_ctrl: randomized jobs against a per-nibble S-box table model.
`timescale 1ns/1ps
module tb_skinny_sbox_layer_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [63:0] din = '0;
    logic [63:0] dout;
    logic        busy;
    logic        done;

    int n_tests = 0;
    int n_fail  = 0;
    int accepted = 0;
    int done_cnt = 0;

    logic [3:0] sbt [16] = '{4'hC, 4'h6, 4'h9, 4'h0, 4'h1, 4'hA, 4'h2, 4'hB,
                             4'h3, 4'h8, 4'h5, 4'hD, 4'h4, 4'hE, 4'h7, 4'hF};

    skinny_sbox_layer_ctrl #(.NIBBLES(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .din(din),
        .dout(dout), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] golden(input logic [63:0] d);
        logic [63:0] r;
        logic [3:0]  n;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            n = d[4*i +: 4];
            r[4*i +: 4] = sbt[n];
        end
        return r;
    endfunction

    function automatic logic [63:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts a job from IDLE, waits (bounded) for done, returns to IDLE.
    task automatic run_job(input logic [63:0] d, output logic [63:0] res,
                           output int lat, output int bcnt, output logic bd);
        start = 1'b1;
        din   = d;
        tick();
        start = 1'b0;
        din   = rnd64();
        accepted++;
        lat  = 0;
        bcnt = 0;
        while (done !== 1'b1 && lat < 40) begin
            if (busy === 1'b1) bcnt++;
            tick();
            lat++;
        end
        res = dout;
        bd  = busy;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        repeat (3) tick();
        n_tests++;
        if (dout !== 64'h0 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: dout=%h busy=%b done=%b, required 0/0/0", dout, busy, done);
        end
        rst_n = 1'b1;
        repeat (2) tick();
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b0 || $isunknown(dout)) begin
            n_fail++;
            $display("FAIL post_reset_idle: busy=%b done=%b dout=%h, required idle with known dout", busy, done, dout);
        end
    endtask

    task automatic test_zero();
        logic [63:0] res; int lat; int bcnt; logic bd;
        run_job(64'h0, res, lat, bcnt, bd);
        n_tests++;
        if (lat !== 17) begin
            n_fail++;
            $display("FAIL zero_latency: got %0d cycles, required 17", lat);
        end
        n_tests++;
        if (res !== 64'hCCCC_CCCC_CCCC_CCCC) begin
            n_fail++;
            $display("FAIL zero_result: got %h, required cccccccccccccccc", res);
        end
        n_tests++;
        if (bcnt !== 17) begin
            n_fail++;
            $display("FAIL zero_busy_cycles: got %0d, required 17", bcnt);
        end
        n_tests++;
        if (bd !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_with_done: busy=%b while done, required 0", bd);
        end
        n_tests++;
        if ($isunknown(res)) begin
            n_fail++;
            $display("FAIL x_after_first_job: dout=%h, required no X", res);
        end
    endtask

    task automatic test_pattern();
        logic [63:0] d, prev, fin, exp;
        d    = 64'hFEDC_BA98_7654_3210;
        prev = dout;
        fin  = golden(d);
        start = 1'b1;
        din   = d;
        tick();
        start = 1'b0;
        din   = rnd64();
        accepted++;
        for (int k = 0; k <= 17; k++) begin
            for (int j = 0; j < 16; j++)
                exp[4*j +: 4] = (j <= k - 2) ? fin[4*j +: 4] : prev[4*j +: 4];
            n_tests++;
            if (dout !== exp) begin
                n_fail++;
                $display("FAIL lane_write_k%0d: dout=%h, required %h", k, dout, exp);
            end
            if (k == 16 || k == 17) begin
                n_tests++;
                if (done !== (k == 17)) begin
                    n_fail++;
                    $display("FAIL pattern_done_k%0d: done=%b, required %b", k, done, (k == 17));
                end
            end
            if (k < 17) tick();
        end
        n_tests++;
        if (dout !== 64'hF7E4_D583_B2A1_096C) begin
            n_fail++;
            $display("FAIL pattern_result: got %h, required f7e4d583b2a1096c", dout);
        end
        tick();
    endtask

    task automatic test_ignore_start();
        logic [63:0] d, res;
        int ndone;
        d = rnd64();
        res = '0;
        ndone = 0;
        start = 1'b1;
        din   = d;
        tick();
        accepted++;
        start = 1'b0;
        for (int c = 0; c < 30; c++) begin
            if (done === 1'b1) begin
                ndone++;
                res = dout;
            end
            start = (c == 5) || (done === 1'b1);
            din   = ~d;
            tick();
        end
        start = 1'b0;
        n_tests++;
        if (ndone !== 1) begin
            n_fail++;
            $display("FAIL ignore_done_pulses: got %0d, required 1", ndone);
        end
        n_tests++;
        if (res !== golden(d)) begin
            n_fail++;
            $display("FAIL ignore_result: got %h, required %h", res, golden(d));
        end
        n_tests++;
        if (dout !== golden(d) || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL ignore_held: dout=%h busy=%b, required %h busy=0", dout, busy, golden(d));
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] d [3];
        int cyc;
        for (int j = 0; j < 3; j++) d[j] = rnd64();
        start = 1'b1;
        din   = d[0];
        tick();
        cyc = 0;
        for (int j = 0; j < 3; j++) begin
            accepted++;
            while (done !== 1'b1 && cyc < 19*j + 27) begin
                tick();
                cyc++;
            end
            n_tests++;
            if (cyc !== 19*j + 17) begin
                n_fail++;
                $display("FAIL b2b_timing_j%0d: done at cycle %0d, required %0d", j, cyc, 19*j + 17);
            end
            n_tests++;
            if (dout !== golden(d[j])) begin
                n_fail++;
                $display("FAIL b2b_result_j%0d: got %h, required %h", j, dout, golden(d[j]));
            end
            if (j < 2) din = d[j+1];
            else       start = 1'b0;
            tick();
            cyc++;
        end
    endtask

    task automatic test_reset_mid();
        logic [63:0] res; int lat; int bcnt; logic bd;
        int ndone;
        start = 1'b1;
        din   = rnd64();
        tick();
        start = 1'b0;
        repeat (8) tick();
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (dout !== 64'h0 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: dout=%h busy=%b done=%b, required 0/0/0", dout, busy, done);
        end
        tick();
        rst_n = 1'b1;
        ndone = 0;
        for (int c = 0; c < 20; c++) begin
            if (done === 1'b1 || busy === 1'b1) ndone++;
            tick();
        end
        n_tests++;
        if (ndone !== 0) begin
            n_fail++;
            $display("FAIL aborted_activity: %0d busy/done cycles, required 0", ndone);
        end
        run_job(64'hFFFF_FFFF_FFFF_FFFF, res, lat, bcnt, bd);
        n_tests++;
        if (res !== 64'hFFFF_FFFF_FFFF_FFFF || lat !== 17) begin
            n_fail++;
            $display("FAIL after_reset_job: got %h lat %0d, required ffffffffffffffff lat 17", res, lat);
        end
    endtask

    task automatic test_random();
        logic [63:0] d, res; int lat; int bcnt; logic bd;
        int acc0, dn0;
        acc0 = accepted;
        dn0  = done_cnt;
        for (int i = 0; i < 1000; i++) begin
            d = rnd64();
            run_job(d, res, lat, bcnt, bd);
            n_tests++;
            if (res !== golden(d) || lat !== 17) begin
                n_fail++;
                $display("FAIL random_job%0d: got %h lat %0d, required %h lat 17", i, res, lat, golden(d));
            end
            repeat ($urandom_range(0, 3)) tick();
        end
        n_tests++;
        if ((done_cnt - dn0) !== (accepted - acc0)) begin
            n_fail++;
            $display("FAIL done_count: got %0d, required %0d", done_cnt - dn0, accepted - acc0);
        end
    endtask

    initial begin
        test_reset();
        test_zero();
        test_pattern();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
